gpr_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined core, successor to the single-cycle register file. Provides NUM_READ combinational read ports, NUM_WRITE synchronous write ports with fixed priority, a per-register busy scoreboard for hazard detection, and a sequential clear sweep that zeroes the file without a reset. Sits between decode (reads, issue) and writeback (writes).

---
 rtl/gpr_pkg.sv | 21 ++
 rtl/gpr_scoreboard.sv | 32 +++
 rtl/gpr_file_mp.sv | 128 ++++++++++++
 tb/tb_gpr_file_mp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared constants, types and helpers for the multi-port GPR file.
package gpr_pkg;

  localparam int GPR_DATA_W   = 32;
  localparam int GPR_NUM_REGS = 32;

  function automatic int gpr_addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  localparam int GPR_ADDR_W = gpr_addr_w(GPR_NUM_REGS);

  typedef logic [GPR_DATA_W-1:0] gpr_data_t;
  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } gpr_state_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: sweep clear beats issue set, issue set beats writeback clear.
module gpr_scoreboard import gpr_pkg::*; #(
  parameter  int NUM_REGS = GPR_NUM_REGS,
  localparam int ADDR_W   = gpr_addr_w(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic [NUM_REGS-1:0] clr_vec,
  input  logic                sweep_en,
  input  logic [ADDR_W-1:0]   sweep_addr,
  output logic [NUM_REGS-1:0] busy
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (sweep_en && sweep_addr == ADDR_W'(r))
          busy[r] <= 1'b0;
        else if (set_en && set_addr == ADDR_W'(r))
          busy[r] <= 1'b1;
        else if (clr_vec[r])
          busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with busy scoreboard and sequential clear sweep.
// Optional same-cycle write-to-read bypass when GPR_BYPASS_EN is defined.
module gpr_file_mp import gpr_pkg::*; #(
  parameter  int DATA_WIDTH = GPR_DATA_W,
  parameter  int NUM_REGS   = GPR_NUM_REGS,
  parameter  int NUM_READ   = 2,
  parameter  int NUM_WRITE  = 2,
  localparam int ADDR_W     = gpr_addr_w(NUM_REGS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]      gprReadRegister,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  gprResult,
  output logic [NUM_READ-1:0]                  gprReadBusy,
  input  logic [NUM_WRITE-1:0]                 gprWriteEnabled,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0]     gprWriteRegister,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] gprWriteInput,
  input  logic                                 issueValid,
  input  logic [ADDR_W-1:0]                    issueRegister,
  input  logic                                 clearStart,
  output logic                                 clearBusy,
  output logic                                 clearDone
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  gpr_state_t                          state, state_nx;
  logic [ADDR_W-1:0]                   idx;
  logic                                done_q;
  logic                                sweep;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 busy;
  logic [NUM_REGS-1:0]                 clr_vec;
  logic [NUM_WRITE-1:0]                wr_act;

  // Write ports are dead while sweeping; r0 is never a target.
  always_comb begin
    wr_act  = '0;
    clr_vec = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      wr_act[p] = gprWriteEnabled[p] && (gprWriteRegister[p] != '0) && !sweep;
      if (wr_act[p]) clr_vec[gprWriteRegister[p]] = 1'b1;
    end
  end

  // Later ports override earlier ones on an address conflict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (sweep) begin
      regs[idx] <= '0;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++)
        if (wr_act[p]) regs[gprWriteRegister[p]] <= gprWriteInput[p];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= sweep && (idx == LAST);
      if (state == IDLE && clearStart)
        idx <= ADDR_W'(1);
      else if (sweep)
        idx <= (idx == LAST) ? '0 : idx + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clearStart)    state_nx = SWEEP;
      SWEEP:   if (idx == LAST)   state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    sweep     = (state == SWEEP);
    clearBusy = sweep;
    clearDone = done_q;
  end

  gpr_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clock      (clock),
    .reset      (reset),
    .set_en     (issueValid && !sweep),
    .set_addr   (issueRegister),
    .clr_vec    (clr_vec),
    .sweep_en   (sweep),
    .sweep_addr (idx),
    .busy       (busy)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0]     ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  bsy;

    assign ra = gprReadRegister[i];

    always_comb begin
      rd  = regs[ra];
      bsy = busy[ra];
`ifdef GPR_BYPASS_EN
      // wr_act already excludes r0 and sweep; highest matching port wins.
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (wr_act[p] && gprWriteRegister[p] == ra) begin
          rd  = gprWriteInput[p];
          bsy = issueValid && (issueRegister == ra);
        end
      end
`endif
      if (ra == '0) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign gprResult[i]   = rd;
    assign gprReadBusy[i] = bsy;
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed vector table plus hand sequences for bypass, reset and clear sweep.
module tb_gpr_file_mp;
  import gpr_pkg::*;

  localparam int AW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0][AW-1:0]   rreg;
  logic [1:0][31:0]     rres;
  logic [1:0]           rbusy;
  logic [1:0]           we;
  logic [1:0][AW-1:0]   wreg;
  logic [1:0][31:0]     wdat;
  logic                 issue;
  logic [AW-1:0]        ireg;
  logic                 cstart, cbusy, cdone;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_file_mp dut (
    .clock            (clk),
    .reset            (rst_n),
    .gprReadRegister  (rreg),
    .gprResult        (rres),
    .gprReadBusy      (rbusy),
    .gprWriteEnabled  (we),
    .gprWriteRegister (wreg),
    .gprWriteInput    (wdat),
    .issueValid       (issue),
    .issueRegister    (ireg),
    .clearStart       (cstart),
    .clearBusy        (cbusy),
    .clearDone        (cdone)
  );

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [31:0]   wd0;
    logic [AW-1:0] wa1;
    logic [31:0]   wd1;
    logic          iv;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [31:0]   e0;
    logic [31:0]   e1;
    logic [1:0]    eb;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    we     = '0;
    wreg   = '0;
    wdat   = '0;
    issue  = 1'b0;
    ireg   = '0;
    cstart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, kd, bad;
    vt[0] = '{2'b11, 5'd5,  32'h11,   5'd5,  32'h22,   1'b0, 5'd0,  5'd5,  5'd0,  32'h22,   32'h0,  2'b00};
    vt[1] = '{2'b01, 5'd0,  32'hFFFF, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd5,  32'h0,    32'h22, 2'b00};
    vt[2] = '{2'b11, 5'd1,  32'hA1,   5'd2,  32'hB2,   1'b0, 5'd0,  5'd1,  5'd2,  32'hA1,   32'hB2, 2'b00};
    vt[3] = '{2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd7,  5'd7,  5'd5,  32'h0,    32'h22, 2'b01};
    vt[4] = '{2'b01, 5'd7,  32'h77,   5'd0,  32'h0,    1'b1, 5'd7,  5'd7,  5'd1,  32'h77,   32'hA1, 2'b01};
    vt[5] = '{2'b10, 5'd0,  32'h0,    5'd7,  32'h78,   1'b0, 5'd0,  5'd7,  5'd1,  32'h78,   32'hA1, 2'b00};
    vt[6] = '{2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd0,  5'd0,  5'd7,  32'h0,    32'h78, 2'b00};
    vt[7] = '{2'b01, 5'd3,  32'h33,   5'd0,  32'h0,    1'b1, 5'd9,  5'd3,  5'd9,  32'h33,   32'h0,  2'b10};
    vt[8] = '{2'b10, 5'd0,  32'h0,    5'd9,  32'h99,   1'b0, 5'd0,  5'd9,  5'd3,  32'h99,   32'h33, 2'b00};
    vt[9] = '{2'b11, 5'd31, 32'hDEAD, 5'd31, 32'hBEEF, 1'b1, 5'd12, 5'd31, 5'd12, 32'hBEEF, 32'h0,  2'b10};

    idle_in();
    rreg = {5'd31, 5'd5};
    #2;
    check("reset_rd0",   rres[0], 32'h0);
    check("reset_rd1",   rres[1], 32'h0);
    check("reset_busy",  32'(rbusy), 32'h0);
    check("reset_cbusy", 32'(cbusy), 32'h0);
    check("reset_cdone", 32'(cdone), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      we      = vt[i].we;
      wreg[0] = vt[i].wa0;
      wdat[0] = vt[i].wd0;
      wreg[1] = vt[i].wa1;
      wdat[1] = vt[i].wd1;
      issue   = vt[i].iv;
      ireg    = vt[i].ia;
      rreg[0] = vt[i].ra0;
      rreg[1] = vt[i].ra1;
      @(posedge clk);
      #1 idle_in();
      #1;
      check($sformatf("vec%0d_rd0", i), rres[0], vt[i].e0);
      check($sformatf("vec%0d_rd1", i), rres[1], vt[i].e1);
      check($sformatf("vec%0d_busy", i), 32'(rbusy), 32'(vt[i].eb));
    end

    // Same-cycle read of a register being written, with busy set beforehand.
    @(negedge clk);
    issue = 1'b1; ireg = 5'd3;
    @(posedge clk);
    #1 idle_in();
    @(negedge clk);
    we = 2'b01; wreg[0] = 5'd3; wdat[0] = 32'hABCD;
    rreg = {5'd3, 5'd3};
    #1;
`ifdef GPR_BYPASS_EN
    check("bypass_same_rd",   rres[0], 32'hABCD);
    check("bypass_same_busy", 32'(rbusy[0]), 32'h0);
`else
    check("nobypass_same_rd",   rres[0], 32'h33);
    check("nobypass_same_busy", 32'(rbusy[0]), 32'h1);
`endif
    @(posedge clk);
    #1 idle_in();
    #1;
    check("bypass_next_rd",   rres[1], 32'hABCD);
    check("bypass_next_busy", 32'(rbusy[1]), 32'h0);

    // Asynchronous reset between edges.
    @(negedge clk);
    rreg = {5'd12, 5'd31};
    #1;
    check("pre_rst_r31",  rres[0], 32'hBEEF);
    check("pre_rst_busy", 32'(rbusy[1]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_r31",   rres[0], 32'h0);
    check("midrst_busy",  32'(rbusy), 32'h0);
    check("midrst_cbusy", 32'(cbusy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill r1..r31, mark r10 busy, then sweep with writes/issue/start held.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      we = 2'b01; wreg[0] = AW'(r); wdat[0] = 32'h1000 + 32'(r);
      issue = (r == 31); ireg = 5'd10;
    end
    @(negedge clk);
    idle_in();
    rreg = {5'd10, 5'd30};
    #1;
    check("fill_r30",     rres[0], 32'h101E);
    check("fill_busy_r10", 32'(rbusy[1]), 32'h1);
    @(negedge clk);
    cstart = 1'b1;
    @(posedge clk);
    #1;
    we = 2'b11; wreg = {5'd30, 5'd4}; wdat = {32'hFFFF, 32'hEEEE};
    issue = 1'b1; ireg = 5'd6;
    nb = 0; nd = 0; kd = -1;
    for (int k = 0; k < 40; k++) begin
      if (cbusy) nb++;
      if (cdone) begin
        nd++;
        kd = k;
        idle_in();
      end
      @(posedge clk);
      #1;
    end
    idle_in();
    check("sweep_busy_cycles", 32'(nb), 32'd31);
    check("sweep_done_pulses", 32'(nd), 32'd1);
    check("sweep_done_cycle",  32'(kd), 32'd31);
    bad = 0;
    for (int r = 1; r < 32; r++) begin
      rreg[0] = AW'(r);
      #1;
      if (rres[0] !== 32'h0) bad++;
    end
    check("sweep_regs_nonzero", 32'(bad), 32'd0);
    rreg = {5'd10, 5'd6};
    #1;
    check("sweep_busy_r6_r10", 32'(rbusy), 32'h0);

    // Reset lands during the sweep.
    @(negedge clk);
    we = 2'b11; wreg = {5'd20, 5'd2}; wdat = {32'h6, 32'h5};
    issue = 1'b1; ireg = 5'd8;
    @(negedge clk);
    idle_in();
    cstart = 1'b1;
    @(posedge clk);
    #1 cstart = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("sweep10_cbusy_pre", 32'(cbusy), 32'h1);
    rst_n = 1'b0;
    rreg = {5'd8, 5'd20};
    #1;
    check("sweeprst_cbusy", 32'(cbusy), 32'h0);
    check("sweeprst_r20",   rres[0], 32'h0);
    check("sweeprst_busy",  32'(rbusy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (cdone) nd++;
      if (cbusy) nb++;
    end
    check("sweeprst_no_done",  32'(nd), 32'd0);
    check("sweeprst_idle",     32'(nb), 32'd0);
    check("sweeprst_r20_after", rres[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
